// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: funct3 sizes, FSM states and
// the access legality check used when DMEM_MISALIGN_TRAP_EN is defined.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Flags misaligned half/word accesses and funct3 codes with no legal meaning
  // for the given direction (1xx has no store form).
  function automatic logic dmem_access_err(input logic we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (we && funct3[2]);
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// Byte-lane steering for the data memory: store byte-enables with replicated
// write data, and load byte/half extraction with sign or zero extension.
module dmem_lane_ext
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_bytes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_bytes[gi] = rword[gi*8 +: 8];
  end

  assign sel_byte = lane_bytes[addr_lo];
  assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    unique case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = rword;
    unique case (funct3)
      F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata_ext = {24'h0, sel_byte};
      F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata_ext = {16'h0, sel_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable wait states over a word array.
// Optional alignment/legality trapping is enabled by DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [ADDR_W+1:0]     addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W-1:0]     rdata_reg;
  logic                  err_reg;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  acc_we;
  logic [2:0]            acc_funct3;
  logic [ADDR_W+1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  acc_err;
  logic [ADDR_W-1:0]     idx;
  logic [DATA_W-1:0]     rword;
  logic [3:0]            be;
  logic [DATA_W-1:0]     wdata_rep;
  logic [DATA_W-1:0]     rdata_ext;
  logic                  commit;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // With LATENCY = 1 the commit edge is the accept edge, so use live request fields.
  assign acc_we     = (state_reg == IDLE) ? req_we                : we_reg;
  assign acc_funct3 = (state_reg == IDLE) ? req_funct3            : funct3_reg;
  assign acc_addr   = (state_reg == IDLE) ? req_addr[ADDR_W+1:0]  : addr_reg;
  assign acc_wdata  = (state_reg == IDLE) ? req_wdata             : wdata_reg;

  assign idx   = acc_addr[ADDR_W+1:2];
  assign rword = mem[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign acc_err = dmem_access_err(acc_we, acc_funct3, acc_addr[1:0]);
`else
  assign acc_err = 1'b0;
`endif

  dmem_lane_ext u_lane_ext (
    .funct3    (acc_funct3),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // cnt_reg counts the wait cycles still owed, including the current one.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          cnt_next   = CNT_INIT;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = (cnt_reg == 4'd0) ? 4'd0 : cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign commit = reset && (state_reg != RESP) && (state_next == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req_valid) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr[ADDR_W+1:0];
        wdata_reg  <= req_wdata;
      end
      if (commit) begin
        rdata_reg <= (acc_we || acc_err) ? '0 : rdata_ext;
        err_reg   <= acc_err;
      end
    end
  end

  // Array contents survive reset; only a committed, legal store touches them.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table-driven load/store vectors plus
// hand-written handshake-hold, wrap and reset-abort sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(7), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request, waits for its response and checks latency and pulse width.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int n;
    int lat;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    chk("latency", 32'(lat), 32'(LAT));
    @(negedge clk);
    chk("rsp_pulse_one_cycle", 32'(rsp_valid), 32'd0);
    $display("txn we=%0b f3=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0b lat=%0d",
             we, f3, addr, wdata, rdata, err, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          accepts;
    int          rsps;
    int          overlap;
    int          busy_bad;
    logic        rsp_seen;

    vecs[0]  = '{1'b1, F3_W,  32'h10,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, F3_B,  32'h11,  32'hABCDEF80, 32'h0};
    vecs[3]  = '{1'b0, F3_B,  32'h11,  32'h0,        32'hFFFFFF80};
    vecs[4]  = '{1'b0, F3_BU, 32'h11,  32'h0,        32'h00000080};
    vecs[5]  = '{1'b0, F3_W,  32'h10,  32'h0,        32'hDEAD80EF};
    vecs[6]  = '{1'b1, F3_H,  32'h12,  32'h1234CAFE, 32'h0};
    vecs[7]  = '{1'b0, F3_H,  32'h12,  32'h0,        32'hFFFFCAFE};
    vecs[8]  = '{1'b0, F3_HU, 32'h12,  32'h0,        32'h0000CAFE};
    vecs[9]  = '{1'b0, F3_W,  32'h10,  32'h0,        32'hCAFE80EF};
    vecs[10] = '{1'b0, F3_B,  32'h13,  32'h0,        32'hFFFFFFCA};
    vecs[11] = '{1'b0, F3_BU, 32'h13,  32'h0,        32'h000000CA};
    vecs[12] = '{1'b1, F3_W,  32'h200, 32'h12345678, 32'h0};
    vecs[13] = '{1'b0, F3_W,  32'h000, 32'h0,        32'h12345678};
    vecs[14] = '{1'b0, F3_B,  32'h003, 32'h0,        32'h00000012};
    vecs[15] = '{1'b0, F3_B,  32'h001, 32'h0,        32'h00000056};
    vecs[16] = '{1'b0, F3_H,  32'h000, 32'h0,        32'h00005678};
    vecs[17] = '{1'b0, F3_HU, 32'h002, 32'h0,        32'h00001234};

    // Reset held for three cycles, then idle state checked.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'd0);
    end

    // Handshake hold: valid high across WAIT and RESP, one accept per LAT+1 cycles.
    @(negedge clk);
    req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_valid = 1'b1;
    accepts = 0; rsps = 0; overlap = 0; busy_bad = 0;
    for (int c = 0; c < 3 * (LAT + 1); c++) begin
      if (req_valid && req_ready) accepts++;
      if (rsp_valid) rsps++;
      if (rsp_valid && req_ready) overlap++;
      if (busy == req_ready) busy_bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    $display("txn hold: accepts=%0d responses=%0d", accepts, rsps);
    chk("hold_accepts", 32'(accepts), 32'd3);
    chk("hold_responses", 32'(rsps), 32'd3);
    chk("hold_ready_in_resp", 32'(overlap), 32'd0);
    chk("hold_busy_vs_ready", 32'(busy_bad), 32'd0);
    chk("hold_last_rdata", rsp_rdata, 32'hCAFE80EF);

    // Reset abort: a store interrupted during WAIT must not reach the array.
    issue(1'b1, F3_W, 32'h20, 32'h11111111, rd, er);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'hBAD0BAD0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy_after_accept", 32'(busy), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    rsp_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
    chk("abort_busy_in_reset", 32'(busy), 32'd0);
    reset = 1'b1;
    $display("txn reset abort of sw 0xBAD0BAD0 @0x20");
    issue(1'b0, F3_W, 32'h20, 32'h0, rd, er);
    chk("abort_old_value", rd, 32'h11111111);

`ifdef DMEM_MISALIGN_TRAP_EN
    issue(1'b0, F3_W, 32'h12, 32'h0, rd, er);
    chk("trap_lw_mis_err", 32'(er), 32'd1);
    chk("trap_lw_mis_rdata", rd, 32'd0);
    issue(1'b1, F3_H, 32'h13, 32'h0000FFFF, rd, er);
    chk("trap_sh_mis_err", 32'(er), 32'd1);
    issue(1'b0, F3_W, 32'h10, 32'h0, rd, er);
    chk("trap_word_unchanged", rd, 32'hCAFE80EF);
    issue(1'b0, 3'b011, 32'h10, 32'h0, rd, er);
    chk("trap_illegal_f3_err", 32'(er), 32'd1);
`else
    issue(1'b0, F3_H, 32'h13, 32'h0, rd, er);
    chk("lh_ignores_addr0", rd, 32'hFFFFCAFE);
    chk("lh_no_err", 32'(er), 32'd0);
    issue(1'b0, 3'b011, 32'h12, 32'h0, rd, er);
    chk("f3_011_as_word", rd, 32'hCAFE80EF);
    chk("f3_011_no_err", 32'(er), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
